// File: rtl/mux5_scan_ctrl_if.sv
// Bundle of the sweep controls, mux data and sample outputs for mux5_scan_ctrl.
// master = whoever drives start/stop and supplies m_in; slave = the sequencer.
interface mux5_scan_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [4:0]       chan_mask;
    logic [WIDTH-1:0] m_in;
    logic [2:0]       s;
    logic [WIDTH-1:0] sample;
    logic [2:0]       sample_ch;
    logic             sample_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, mode, chan_mask, m_in,
        input  s, sample, sample_ch, sample_valid, busy, done
    );

    modport slave (
        input  start, stop, mode, chan_mask, m_in,
        output s, sample, sample_ch, sample_valid, busy, done
    );
endinterface

// File: rtl/mux5_scan_ctrl.sv
// Sweeps the 5:1 mux select over the enabled channels, settles DWELL cycles, then registers a tagged sample.
// Optional MUX5_SCAN_CHGDET_EN: only strobe a sample when it differs from that channel's previous one.
module mux5_scan_ctrl #(
    parameter int WIDTH = 3,
    parameter int DWELL = 4
) (
    input logic              clk,
    input logic              rst_n,
    mux5_scan_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [4:0]       mask_q, mask_d;
    logic             mode_q, mode_d;
    logic [2:0]       s_q, s_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [2:0]       sample_ch_q, sample_ch_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             emit;

`ifdef MUX5_SCAN_CHGDET_EN
    logic [WIDTH-1:0] hist_q [5];
    logic [WIDTH-1:0] hist_d [5];
    logic [4:0]       hvld_q, hvld_d;
`endif

    // Result is {found, index} of the lowest enabled channel at or above 'from'.
    function automatic logic [3:0] findFrom(input logic [4:0] mask, input logic [2:0] from);
        logic [3:0] hit;
        hit = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) hit = {1'b1, 3'(i)};
        end
        return hit;
    endfunction

    logic [3:0] start_hit, first_hit, next_hit;
    assign start_hit = findFrom(bus.chan_mask, 3'd0);
    assign first_hit = findFrom(mask_q, 3'd0);
    assign next_hit  = findFrom(mask_q, s_q + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mask_q      <= 5'd0;
            mode_q      <= 1'b0;
            s_q         <= 3'd0;
            sample_q    <= '0;
            sample_ch_q <= 3'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MUX5_SCAN_CHGDET_EN
            for (int i = 0; i < 5; i++) hist_q[i] <= '0;
            hvld_q      <= 5'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            s_q         <= s_d;
            sample_q    <= sample_d;
            sample_ch_q <= sample_ch_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MUX5_SCAN_CHGDET_EN
            hist_q      <= hist_d;
            hvld_q      <= hvld_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && (bus.chan_mask != 5'd0)) state_d = SETTLE;
            end
            SETTLE: begin
                if (bus.stop)                       state_d = IDLE;
                else if (cnt_q == 8'(DWELL - 1))    state_d = CAPTURE;
            end
            CAPTURE: begin
                if (bus.stop)                       state_d = IDLE;
                else if (next_hit[3] || mode_q)     state_d = SETTLE;
                else                                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stop always wins over a capture: the sweep ends with Done and no strobe.
    always_comb begin
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        s_d         = s_q;
        sample_d    = sample_q;
        sample_ch_d = sample_ch_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        emit        = 1'b1;
`ifdef MUX5_SCAN_CHGDET_EN
        hist_d      = hist_q;
        hvld_d      = hvld_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_hit[3]) begin
                        mask_d = bus.chan_mask;
                        mode_d = bus.mode;
                        s_d    = start_hit[2:0];
                        cnt_d  = 8'd0;
                        busy_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (bus.stop) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    cnt_d  = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CAPTURE: begin
                if (bus.stop) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    cnt_d  = 8'd0;
                end else begin
`ifdef MUX5_SCAN_CHGDET_EN
                    emit           = !hvld_q[s_q] || (hist_q[s_q] != bus.m_in);
                    hist_d[s_q]    = bus.m_in;
                    hvld_d[s_q]    = 1'b1;
`endif
                    if (emit) begin
                        sample_d    = bus.m_in;
                        sample_ch_d = s_q;
                        valid_d     = 1'b1;
                    end
                    cnt_d = 8'd0;
                    if (next_hit[3]) begin
                        s_d = next_hit[2:0];
                    end else if (mode_q) begin
                        s_d = first_hit[2:0];
                    end else begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.s            = s_q;
    assign bus.sample       = sample_q;
    assign bus.sample_ch    = sample_ch_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_mux5_scan_ctrl.sv
// Randomised plus directed bench for mux5_scan_ctrl against a time-slot reference model.
// Builds with or without MUX5_SCAN_CHGDET_EN; the change-detect scenario only runs when defined.
module tb_mux5_scan_ctrl;
    localparam int WIDTH  = 3;
    localparam int DWELL  = 4;
    localparam int PERIOD = DWELL + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] mux_off = 3'd0;
    logic       force_en = 1'b0;
    logic [2:0] force_val = 3'd0;

    int checks = 0;
    int fails  = 0;

    mux5_scan_ctrl_if #(.WIDTH(WIDTH)) bus();

    mux5_scan_ctrl #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Mux model: channel n presents n+1 (plus a per-run offset), or a forced value.
    assign bus.m_in = force_en ? force_val : 3'(bus.s + 3'd1 + mux_off);

    bit         m_busy, m_cont, m_sv, m_done;
    int         m_k;
    int         m_chans[$];
    logic [2:0] m_s, m_sample, m_sample_ch;
    logic [2:0] m_hist [5];
    bit   [4:0] m_hvld;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [2:0] capVal(input int ch);
        return force_en ? force_val : 3'(ch + 1 + int'(mux_off));
    endfunction

    task automatic modelReset();
        m_busy = 0; m_cont = 0; m_sv = 0; m_done = 0; m_k = 0;
        m_chans.delete();
        m_s = 3'd0; m_sample = 3'd0; m_sample_ch = 3'd0;
        for (int i = 0; i < 5; i++) m_hist[i] = 3'd0;
        m_hvld = 5'd0;
    endtask

    // Sweep timeline: slot j spans cycles [j*PERIOD, (j+1)*PERIOD) after the accept edge.
    task automatic modelStep(input bit st, input bit sp, input logic [4:0] mask, input bit md);
        int slot, n, ch;
        bit emit;
        logic [2:0] v;
        m_sv = 0;
        m_done = 0;
        if (!m_busy) begin
            if (st) begin
                if (mask != 5'd0) begin
                    m_chans.delete();
                    for (int i = 0; i < 5; i++) if (mask[i]) m_chans.push_back(i);
                    m_cont = md;
                    m_busy = 1;
                    m_k = 0;
                    m_s = 3'(m_chans[0]);
                end else begin
                    m_done = 1;
                end
            end
        end else if (sp) begin
            m_busy = 0;
            m_done = 1;
        end else begin
            m_k++;
            if (m_k % PERIOD == 0) begin
                slot = m_k / PERIOD;
                n = m_chans.size();
                ch = m_chans[(slot - 1) % n];
                v = capVal(ch);
                emit = 1;
`ifdef MUX5_SCAN_CHGDET_EN
                emit = !m_hvld[ch] || (m_hist[ch] != v);
                m_hist[ch] = v;
                m_hvld[ch] = 1'b1;
`endif
                if (emit) begin
                    m_sv = 1;
                    m_sample = v;
                    m_sample_ch = 3'(ch);
                end
                if (!m_cont && slot == n) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_s = 3'(m_chans[slot % n]);
                end
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".s"},         32'(bus.s),            32'(m_s));
        checkOutput({tag, ".busy"},      32'(bus.busy),         32'(m_busy));
        checkOutput({tag, ".done"},      32'(bus.done),         32'(m_done));
        checkOutput({tag, ".valid"},     32'(bus.sample_valid), 32'(m_sv));
        checkOutput({tag, ".sample"},    32'(bus.sample),       32'(m_sample));
        checkOutput({tag, ".sample_ch"}, 32'(bus.sample_ch),    32'(m_sample_ch));
    endtask

    task automatic applyStimulus(input string tag, input bit st, input bit sp,
                                 input logic [4:0] mask, input bit md);
        bus.start = st;
        bus.stop = sp;
        bus.chan_mask = mask;
        bus.mode = md;
        @(posedge clk);
        modelStep(st, sp, mask, md);
        #1;
        checkAll(tag);
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 5'(i), 1'(i));
    endtask

    task automatic resetPulse(input string tag);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkAll(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.chan_mask = 0; bus.mode = 0;
        modelReset();
        #1;
        checkAll("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles("post_por", 3);

        // Single sweep over channels 0, 2, 4.
        applyStimulus("t2_start", 1'b1, 1'b0, 5'b10101, 1'b0);
        idleCycles("t2_run", 18);

        // Continuous on channel 1, stopped on a capture cycle.
        applyStimulus("t3_start", 1'b1, 1'b0, 5'b00010, 1'b1);
        idleCycles("t3_run", 14);
        applyStimulus("t3_stop", 1'b0, 1'b1, 5'b00010, 1'b1);
        idleCycles("t3_after", 4);

        applyStimulus("t4_empty", 1'b1, 1'b0, 5'b00000, 1'b0);
        idleCycles("t4_after", 4);

        // Start held and mask churning while a full sweep runs.
        applyStimulus("t5_start", 1'b1, 1'b0, 5'b11111, 1'b0);
        for (int i = 0; i < 24; i++)
            applyStimulus("t5_run", 1'b1, 1'b0, 5'($urandom), 1'($urandom));
        idleCycles("t5_after", 4);

        applyStimulus("both_idle", 1'b1, 1'b1, 5'b01001, 1'b0);
        idleCycles("both_run", 12);

        // Reset in the middle of a continuous sweep; nothing may follow until Start.
        applyStimulus("t1_start", 1'b1, 1'b0, 5'b11010, 1'b1);
        idleCycles("t1_run", 7);
        resetPulse("t1_reset");
        idleCycles("t1_after", 12);

        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) mux_off = 3'($urandom);
            applyStimulus("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
        end
        applyStimulus("rand_stop", 1'b0, 1'b1, 5'd0, 1'b0);
        idleCycles("rand_after", 3);

`ifdef MUX5_SCAN_CHGDET_EN
        resetPulse("t6_reset");
        force_en = 1'b1;
        force_val = 3'd3;
        applyStimulus("t6_start", 1'b1, 1'b0, 5'b00001, 1'b1);
        idleCycles("t6_stable", 20);
        force_val = 3'd6;
        idleCycles("t6_change", 15);
        applyStimulus("t6_stop", 1'b0, 1'b1, 5'b00001, 1'b1);
        force_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
